demux_bit_sequencer: RTL and testbench
======================================

// Module: demux_bit_sequencer
//
// PURPOSE
// Upstream feeder for the 1-to-8 bit demux. Accepts (channel, word) pairs over a
// valid/ready handshake and buffers them in a small FIFO. Serializes each word one
// bit per clock onto out_i, which drives the demux data input i. Holds out_s, which
// drives the demux select s, at the word's channel for the whole word, so every bit
// of a word lands on the same demux output y[out_s].
//
// PARAMETERS
// DATA_W      8  bits per word; number of serial cycles per word
// CHAN_W      3  channel id width; drives demux select (8 channels)
// FIFO_DEPTH  4  input buffer entries; power of 2, >= 2
// MSB_FIRST   0  0: LSB shifted out first; 1: MSB first
//
// PORTS
// clk         in   1                   rising-edge clock
// rst         in   1                   synchronous, active-high reset
// in_valid    in   1                   upstream word valid
// in_ready    out  1                   block can accept a word this cycle
// in_chan     in   CHAN_W              destination channel of word
// in_data     in   DATA_W              word to serialize
// stall       in   1                   downstream pause request
// out_i       out  1                   serial bit to demux i
// out_s       out  CHAN_W              channel select to demux s
// out_valid   out  1                   out_i carries a live bit this cycle
// out_last    out  1                   current bit is last bit of word
// busy        out  1                   serializer in SHIFT state
// fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently buffered
//
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): FIFO flushed, FSM -> IDLE, bit counter 0.
//   Registered outputs out_i, out_s, out_valid, out_last, busy and fifo_count all 0.
//   in_ready = !rst && !full (combinational); it is 0 while rst is high.
// - Push: in_valid && in_ready at an edge writes {in_chan,in_data}.
//   No push when full, even if a pop happens in the same cycle.
// - Push and pop in the same cycle (not full): both take effect; fifo_count unchanged.
// - FSM IDLE: if FIFO is not empty and stall=0, pop the head, load the shift register
//   and out_s, clear the counter, and go to SHIFT. The first bit is visible after that edge.
// - FSM SHIFT, stall=0: present one bit per cycle. out_valid=1.
//   out_last=1 when counter==DATA_W-1.
// - After the last bit:
//   - FIFO not empty: pop the next word at that same edge and stay in SHIFT.
//     Back-to-back words have zero bubble cycles.
//   - FIFO empty: go to IDLE.
// - stall=1 in SHIFT: shift register, counter and out_s are frozen. out_valid=0 and
//   out_i=0 while stalled. The bit is re-presented when stall drops, so no bit is lost
//   or repeated.
// - stall=1 in IDLE: no pop. stall never blocks pushes.
// - Whenever out_valid=0: out_i=0, out_last=0, and out_s holds its last value.
//   The demux then outputs all zeros.
// - Latency: word accepted into an empty FIFO at edge k while IDLE, stall=0.
//   First bit is valid after edge k+1 and the last bit after edge k+DATA_W.
// - Bit order: MSB_FIRST=0 sends in_data[0] first; MSB_FIRST=1 sends in_data[DATA_W-1] first.
// - Reset mid-word: the word in flight and all queued words are discarded.
//   Outputs are 0 on the next cycle.
// - busy=1 from the load edge through the final bit of the last queued word.
//
// TESTING
// 1 Reset: assert rst 2 cycles -> all outputs 0, in_ready=0.
//   Deassert -> in_ready=1, fifo_count=0.
// 2 Single word: push chan=5, data=0xA5 (MSB_FIRST=0) -> 8 valid cycles, out_s=5,
//   out_i=1,0,1,0,0,1,0,1, out_last on the 8th only. Then out_valid=0, busy=0.
// 3 Back-to-back: push (2,0xFF) then (6,0x00) consecutively -> 16 contiguous valid cycles.
//   out_s changes 2->6 exactly at bit 9. Exactly two out_last pulses.
// 4 Full FIFO: stall=1 while pushing 5 words -> 4 accepted, fifo_count=4, in_ready=0.
//   Release stall -> 32 valid bits, in order.
// 5 Mid-word stall: stall for 3 cycles after bit 3 of 0x3C -> out_valid=0 for those cycles.
//   Resumed sequence equals 0x3C with no lost or duplicate bits.
// 6 Reset mid-word: rst at bit 4 with 2 words queued -> next cycle outputs 0 and
//   fifo_count=0. No further bits until a new push.

Source files
------------

// File: rtl/demux_bit_sequencer.sv
// demux_bit_sequencer: buffers (channel, word) pairs and serializes each
// word one bit per clock onto a 1-to-8 demux, holding the select per word.
module demux_bit_sequencer #(
  parameter int DATA_W     = 8,
  parameter int CHAN_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHAN_W-1:0]             in_chan,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          stall,
  output logic                          out_i,
  output logic [CHAN_W-1:0]             out_s,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int EW = CHAN_W + DATA_W;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [NW-1:0]     bcnt_q, bcnt_d;
  logic [CHAN_W-1:0] s_q, s_d;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic empty, full, push, pop;
  logic last_bit, cur_bit;
  logic [EW-1:0] head;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_q];

  assign last_bit = (bcnt_q == NW'(DATA_W - 1));
  assign cur_bit  = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_chan, in_data};
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    s_d     = s_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !stall) begin
          pop     = 1'b1;
          sh_d    = head[DATA_W-1:0];
          s_d     = head[EW-1:DATA_W];
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (!last_bit) begin
            bcnt_d = bcnt_q + 1'b1;
            sh_d   = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0}
                               : {1'b0, sh_q[DATA_W-1:1]};
          end else if (!empty) begin
            // chain straight into the next word: no bubble
            pop    = 1'b1;
            sh_d   = head[DATA_W-1:0];
            s_d    = head[EW-1:DATA_W];
            bcnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcnt_q  <= '0;
      s_q     <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign out_valid  = busy && !stall;
  assign out_i      = out_valid && cur_bit;
  assign out_last   = out_valid && last_bit;
  assign out_s      = s_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// tb_demux_bit_sequencer: scoreboard of expected serial bits plus a
// table of words with hand-written expected bit streams.
module tb_demux_bit_sequencer;

  localparam int DW = 8;
  localparam int CWID = 3;
  localparam bit MSBF = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [CWID-1:0] in_chan = '0;
  logic [DW-1:0] in_data = '0;
  logic stall = 1'b0;
  logic out_i;
  logic [CWID-1:0] out_s;
  logic out_valid, out_last, busy;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  demux_bit_sequencer #(
    .DATA_W(DW), .CHAN_W(CWID), .FIFO_DEPTH(4), .MSB_FIRST(MSBF)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .in_data(in_data),
    .stall(stall),
    .out_i(out_i), .out_s(out_s),
    .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [CWID-1:0] c;
    logic b;
    logic l;
  } exp_t;

  typedef struct packed {
    logic [CWID-1:0] c;
    logic [DW-1:0] w;
  } rx_t;

  typedef struct {
    logic [CWID-1:0] c;
    logic [DW-1:0] d;
    logic [DW-1:0] stream;
  } vec_t;

  exp_t sb[$];
  rx_t rxq[$];
  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int lcount = 0;
  int run = 0;
  int max_run = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] rx_word = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        exp_t e;
        logic [DW-1:0] nw;
        vcount++;
        run++;
        if (run > max_run) max_run = run;
        nw = {rx_word[DW-2:0], out_i};
        rx_word = nw;
        if (out_last) begin
          lcount++;
          rxq.push_back({out_s, nw});
        end
        if (sb.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("bit_out_i", {31'd0, out_i}, {31'd0, e.b});
          chk("bit_out_s", {29'd0, out_s}, {29'd0, e.c});
          chk("bit_last", {31'd0, out_last}, {31'd0, e.l});
          chk("bit_busy", {31'd0, busy}, 1);
        end
      end else begin
        run = 0;
        chk("idle_zero", {30'd0, out_i, out_last}, 0);
      end
    end
  end

  task automatic push(input logic [CWID-1:0] c, input logic [DW-1:0] d);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("push_timeout", 1, 0);
      return;
    end
    in_valid = 1'b1;
    in_chan = c;
    in_data = d;
    @(posedge clk);
    for (int b = 0; b < DW; b++) begin
      exp_t e;
      e.c = c;
      e.b = MSBF ? d[DW-1-b] : d[b];
      e.l = (b == DW - 1);
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drain"}, sb.size(), 0);
    chk({nm, "_busy"}, {31'd0, busy}, 0);
    chk({nm, "_valid"}, {31'd0, out_valid}, 0);
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    while (vcount < n && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_bits", vcount, n);
  endtask

  vec_t vt[5];
  rx_t r;
  int base, lbase;

  initial begin
    vt[0] = '{3'd5, 8'hA5, 8'b10100101};
    vt[1] = '{3'd0, 8'h01, 8'b10000000};
    vt[2] = '{3'd7, 8'h80, 8'b00000001};
    vt[3] = '{3'd3, 8'h0F, 8'b11110000};
    vt[4] = '{3'd4, 8'h36, 8'b01101100};

    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {25'd0, out_i, out_s, out_valid, out_last, busy},
        0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 1);
    chk("post_rst_count", {29'd0, fifo_count}, 0);

    // table: one word at a time, compare reassembled stream
    for (int i = 0; i < 5; i++) begin
      base = vcount;
      push(vt[i].c, vt[i].d);
      wait_idle("vec");
      chk("vec_nbits", vcount - base, DW);
      if (rxq.size() != 1) begin
        chk("vec_rx_size", rxq.size(), 1);
        rxq.delete();
      end else begin
        r = rxq.pop_front();
        chk("vec_stream", {24'd0, r.w}, {24'd0, vt[i].stream});
        chk("vec_chan", {29'd0, r.c}, {29'd0, vt[i].c});
      end
    end

    // back-to-back words
    base = vcount;
    lbase = lcount;
    max_run = 0;
    push(3'd2, 8'hFF);
    push(3'd6, 8'h00);
    wait_idle("b2b");
    chk("b2b_bits", vcount - base, 16);
    chk("b2b_run", max_run, 16);
    chk("b2b_lasts", lcount - lbase, 2);
    rxq.delete();

    // fill FIFO while stalled
    stall = 1'b1;
    push(3'd1, 8'h11);
    push(3'd2, 8'h22);
    push(3'd3, 8'h33);
    push(3'd4, 8'h44);
    @(negedge clk);
    chk("full_count", {29'd0, fifo_count}, 4);
    chk("full_ready", {31'd0, in_ready}, 0);
    in_valid = 1'b1;
    in_chan = 3'd7;
    in_data = 8'h77;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("full_reject", {29'd0, fifo_count}, 4);
    chk("stall_idle_busy", {31'd0, busy}, 0);
    base = vcount;
    @(posedge clk);
    #1 stall = 1'b0;
    wait_idle("full");
    chk("full_bits", vcount - base, 32);
    chk("full_words", rxq.size(), 4);
    for (int i = 0; i < 4 && rxq.size() > 0; i++) begin
      r = rxq.pop_front();
      chk("full_order", {29'd0, r.c}, i + 1);
    end
    rxq.delete();

    // mid-word stall
    base = vcount;
    push(3'd1, 8'h3C);
    wait_bits(base + 3);
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 0);
      chk("stall_busy", {31'd0, busy}, 1);
    end
    @(posedge clk);
    #1 stall = 1'b0;
    wait_idle("stall");
    chk("stall_bits", vcount - base, DW);
    if (rxq.size() == 1) begin
      r = rxq.pop_front();
      chk("stall_stream", {24'd0, r.w}, 8'b00111100);
    end else begin
      chk("stall_rx_size", rxq.size(), 1);
    end
    rxq.delete();

    // reset mid-word with two words queued
    base = vcount;
    push(3'd3, 8'hAA);
    push(3'd4, 8'hBB);
    push(3'd5, 8'hCC);
    wait_bits(base + 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rxq.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs",
        {25'd0, out_i, out_s, out_valid, out_last, busy}, 0);
    chk("mid_rst_count", {29'd0, fifo_count}, 0);
    base = vcount;
    repeat (20) @(negedge clk);
    chk("mid_rst_quiet", vcount - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
